// File: rtl/pht_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pht_pkg
// Purpose  : Shared pattern-history constants, FSM encoding and the
//            saturating counter step used by the PHT and BTB hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
package pht_pkg;

  localparam int c_CTRWIDTH = 2;
  localparam int c_INITCTR  = 1;
  localparam int c_CTR_MAXW = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } pht_state_e;

  // Counters of any width up to c_CTR_MAXW are zero-extended by the caller.
  function automatic logic [c_CTR_MAXW-1:0] sat_inc_dec(
    input logic [c_CTR_MAXW-1:0] ctr,
    input logic [c_CTR_MAXW-1:0] ctr_max,
    input logic                  taken
  );
    localparam logic [c_CTR_MAXW-1:0] c_ONE = c_CTR_MAXW'(1);
    logic [c_CTR_MAXW-1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr < ctr_max) res = ctr + c_ONE;
    end else begin
      if (ctr != '0) res = ctr - c_ONE;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_ctr_next.sv
`default_nettype none
// ============================================================================
// Module   : sat_ctr_next
// Purpose  : Combinational next value of a saturating up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
module sat_ctr_next
  import pht_pkg::*;
#(
  parameter int WIDTH = c_CTRWIDTH
) (
  input  logic [WIDTH-1:0] i_ctr,
  input  logic             i_taken,
  output logic [WIDTH-1:0] o_ctr
);

  localparam logic [c_CTR_MAXW-1:0] c_MAX = c_CTR_MAXW'((1 << WIDTH) - 1);

  assign o_ctr = WIDTH'(sat_inc_dec(c_CTR_MAXW'(i_ctr), c_MAX, i_taken));

endmodule
`default_nettype wire

// File: rtl/pht_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pht_ctrl
// Purpose  : Pattern history table controller: lookup port, saturating
//            read-modify-write update port and a two-entry-per-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module pht_ctrl
  import pht_pkg::*;
#(
  parameter int LOGINDEX = 8,
  parameter int CTRWIDTH = c_CTRWIDTH,
  parameter int INITCTR  = c_INITCTR
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_in,
  input  logic                lk_valid_in,
  input  logic [LOGINDEX-1:0] lk_index_in,
  output logic                pred_valid_out,
  output logic                pred_taken_out,
  output logic [CTRWIDTH-1:0] pred_ctr_out,
  input  logic                upd_valid_in,
  input  logic [LOGINDEX-1:0] upd_index_in,
  input  logic                upd_taken_in,
  output logic                busy_out,
  output logic                ram_we1_out,
  output logic                ram_we2_out,
  output logic [LOGINDEX-1:0] ram_index1_out,
  output logic [LOGINDEX-1:0] ram_index2_out,
  output logic [CTRWIDTH-1:0] ram_data1_out,
  output logic [CTRWIDTH-1:0] ram_data2_out,
  input  logic [CTRWIDTH-1:0] ram_rdata1_in,
  input  logic [CTRWIDTH-1:0] ram_rdata2_in
);

  localparam int                  c_PTRW     = (LOGINDEX > 1) ? LOGINDEX - 1 : 1;
  localparam logic [c_PTRW-1:0]   c_PTR_LAST = c_PTRW'((1 << (LOGINDEX - 1)) - 1);
  localparam logic [c_PTRW-1:0]   c_PTR_ONE  = c_PTRW'(1);
  localparam logic [CTRWIDTH-1:0] c_INIT     = CTRWIDTH'(INITCTR);

  pht_state_e          r_state;
  logic [c_PTRW-1:0]   r_ptr;
  logic                r_busy;
  logic                r_upd_v;
  logic                r_upd_tk;
  logic [LOGINDEX-1:0] r_upd_idx;
  logic                r_pred_valid;
  logic [CTRWIDTH-1:0] r_pred_ctr;

  logic                w_idle;
  logic                w_bypass;
  logic                w_lk_accept;
  logic [CTRWIDTH-1:0] w_upd_ctr;
  logic [CTRWIDTH-1:0] w_lk_ctr;
  logic [LOGINDEX-1:0] w_clr_idx_even;
  logic [LOGINDEX-1:0] w_clr_idx_odd;

  // The pointer addresses an even/odd entry pair.
  generate
    if (LOGINDEX > 1) begin : g_clr_idx_wide
      assign w_clr_idx_even = {r_ptr, 1'b0};
      assign w_clr_idx_odd  = {r_ptr, 1'b1};
    end else begin : g_clr_idx_single
      assign w_clr_idx_even = 1'b0;
      assign w_clr_idx_odd  = 1'b1;
    end
  endgenerate

  sat_ctr_next #(
    .WIDTH (CTRWIDTH)
  ) u_sat_ctr_next (
    .i_ctr   (ram_rdata2_in),
    .i_taken (r_upd_tk),
    .o_ctr   (w_upd_ctr)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign w_bypass    = r_upd_v && (r_upd_idx == lk_index_in);
  assign w_lk_ctr    = w_bypass ? w_upd_ctr : ram_rdata1_in;
  assign w_lk_accept = w_idle && lk_valid_in && !flush_in;

  always_comb begin
    ram_we1_out    = 1'b0;
    ram_we2_out    = r_upd_v;
    ram_index1_out = lk_index_in;
    ram_index2_out = r_upd_idx;
    ram_data1_out  = c_INIT;
    ram_data2_out  = w_upd_ctr;
    if (!w_idle) begin
      ram_we1_out    = 1'b1;
      ram_we2_out    = 1'b1;
      ram_index1_out = w_clr_idx_even;
      ram_index2_out = w_clr_idx_odd;
      ram_data2_out  = c_INIT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_busy       <= 1'b0;
      r_upd_v      <= 1'b0;
      r_upd_tk     <= 1'b0;
      r_upd_idx    <= '0;
      r_pred_valid <= 1'b0;
      r_pred_ctr   <= '0;
    end else begin
      // Updates arriving while clearing are discarded at capture.
      r_upd_v      <= upd_valid_in && w_idle;
      r_upd_tk     <= upd_taken_in;
      r_upd_idx    <= upd_index_in;
      r_pred_valid <= w_lk_accept;
      if (w_lk_accept) r_pred_ctr <= w_lk_ctr;

      case (r_state)
        ST_IDLE: begin
          if (flush_in) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          if (flush_in) begin
            r_ptr <= '0;
          end else if (r_ptr == c_PTR_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + c_PTR_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pred_valid_out = r_pred_valid;
  assign pred_ctr_out   = r_pred_ctr;
  assign pred_taken_out = r_pred_ctr[CTRWIDTH-1];
  assign busy_out       = r_busy;

endmodule
`default_nettype wire
